// File: rtl/ascon_pkg.sv
// Shared definitions for the ASCON-128 decrypt datapath: constants, FSM
// state encoding, the round-constant generator and a 64-bit rotate helper.
package ascon_pkg;

  // ASCON-128 initialization vector (rate 64, a=12, b=6)
  localparam logic [63:0] ASCON_IV = 64'h80400C0600000000;

  // Padding word absorbed for the empty final data block
  localparam logic [63:0] ASCON_PAD = 64'h8000000000000000;

  // Index of the last round of every permutation (p12 and p6 both end at 11)
  localparam logic [3:0] LAST_ROUND = 4'd11;

  // Controller phases; IDLE is encoded as zero so a reset state reads as 0
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    DAT0  = 3'd2,
    DAT1  = 3'd3,
    FINAL = 3'd4
  } state_t;

  // Round constant for round index i: high nibble counts down, low nibble up
  function automatic logic [7:0] round_const(input logic [3:0] i);
    logic [3:0] hi;
    hi = 4'hF - i;
    return {hi, i};
  endfunction

  // Rotate a 64-bit lane right by n positions (n in 1..63)
  function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

endpackage

// File: rtl/ascon_round.sv
// One ASCON permutation round, purely combinational:
// constant addition on x2, bitsliced 5-bit S-box layer, linear diffusion.
// State packing: x[319:256]=x0, x[255:192]=x1, x[191:128]=x2,
// x[127:64]=x3, x[63:0]=x4.
module ascon_round
  import ascon_pkg::*;
(
  input  logic [319:0] x,
  input  logic [7:0]   rc,
  output logic [319:0] x_next
);

  logic [63:0] a0, a1, a2, a3, a4;
  logic [63:0] t0, t1, t2, t3, t4;
  logic [63:0] s0, s1, s2, s3, s4;
  logic [63:0] l0, l1, l2, l3, l4;

  // Constant addition and bitsliced S-box, written as the reference sequence
  always_comb begin
    a0 = x[319:256];
    a1 = x[255:192];
    a2 = x[191:128] ^ {56'd0, rc};
    a3 = x[127:64];
    a4 = x[63:0];

    a0 = a0 ^ a4;
    a4 = a4 ^ a3;
    a2 = a2 ^ a1;

    t0 = ~a0 & a1;
    t1 = ~a1 & a2;
    t2 = ~a2 & a3;
    t3 = ~a3 & a4;
    t4 = ~a4 & a0;

    s0 = a0 ^ t1;
    s1 = a1 ^ t2;
    s2 = a2 ^ t3;
    s3 = a3 ^ t4;
    s4 = a4 ^ t0;

    s1 = s1 ^ s0;
    s0 = s0 ^ s4;
    s3 = s3 ^ s2;
    s2 = ~s2;
  end

  // Linear diffusion layer: each lane XORed with two rotations of itself
  always_comb begin
    l0 = s0 ^ rotr(s0, 19) ^ rotr(s0, 28);
    l1 = s1 ^ rotr(s1, 61) ^ rotr(s1, 39);
    l2 = s2 ^ rotr(s2, 1)  ^ rotr(s2, 6);
    l3 = s3 ^ rotr(s3, 10) ^ rotr(s3, 17);
    l4 = s4 ^ rotr(s4, 7)  ^ rotr(s4, 41);
    x_next = {l0, l1, l2, l3, l4};
  end

endmodule

// File: rtl/ascon_decrypt.sv
// Iterative ASCON-128 decryption of two full 64-bit ciphertext blocks with
// no associated data, one permutation round per clock.
// Optional build macro ASCON_DEC_TAG_CHECK_EN adds tag0/tag1 inputs and a
// tag_ok output; on a tag mismatch the plaintext registers are cleared.
//
// Handshake: start is a single-cycle request honoured only while idle
// (busy=0); busy rises on the load edge and falls on the last round edge,
// and done pulses for exactly one cycle right after that edge. Requests
// while busy are dropped. Inputs must be held from the start edge through
// the second data block; k0/k1 must be held until done.
module ascon_decrypt
  import ascon_pkg::*;
#(
  parameter int ROUNDS_A = 12,
  parameter int ROUNDS_B = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] iv,
  input  logic [63:0] k0,
  input  logic [63:0] k1,
  input  logic [63:0] n0,
  input  logic [63:0] n1,
  input  logic [63:0] cyp0,
  input  logic [63:0] cyp1,
`ifdef ASCON_DEC_TAG_CHECK_EN
  input  logic [63:0] tag0,
  input  logic [63:0] tag1,
  output logic        tag_ok,
`endif
  output logic [63:0] y0,
  output logic [63:0] y1,
  output logic [63:0] y2,
  output logic [63:0] y3,
  output logic [63:0] y4,
  output logic [63:0] pln0,
  output logic [63:0] pln1,
  output logic        busy,
  output logic        done,
  output logic [2:0]  dbg_state
);

  // A permutation of r rounds runs round indices 12-r .. 11
  localparam logic [3:0] START_A = 4'(12 - ROUNDS_A);
  localparam logic [3:0] START_B = 4'(12 - ROUNDS_B);

  state_t       state, state_n;
  logic [3:0]   rnd;
  logic         last;
  logic [7:0]   rc;
  logic [319:0] x;
  logic [319:0] rx;
  logic [63:0]  rx0, rx1, rx2, rx3, rx4;

  assign rc   = round_const(rnd);
  assign last = (rnd == LAST_ROUND);

  ascon_round u_round (
    .x      (x),
    .rc     (rc),
    .x_next (rx)
  );

  assign rx0 = rx[319:256];
  assign rx1 = rx[255:192];
  assign rx2 = rx[191:128];
  assign rx3 = rx[127:64];
  assign rx4 = rx[63:0];

  assign y0 = x[319:256];
  assign y1 = x[255:192];
  assign y2 = x[191:128];
  assign y3 = x[127:64];
  assign y4 = x[63:0];

  assign dbg_state = state;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic: each busy phase ends on its final round index
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = INIT;
      INIT:    if (last)  state_n = DAT0;
      DAT0:    if (last)  state_n = DAT1;
      DAT1:    if (last)  state_n = FINAL;
      FINAL:   if (last)  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Datapath: load, one round per busy edge, and the phase-end operations
  // applied to that same edge's round output
  always_ff @(posedge clk) begin
    if (rst) begin
      x      <= '0;
      rnd    <= '0;
      pln0   <= '0;
      pln1   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
`ifdef ASCON_DEC_TAG_CHECK_EN
      tag_ok <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            x    <= {iv, k0, k1, n0, n1};
            rnd  <= START_A;
            busy <= 1'b1;
          end
        end
        INIT: begin
          x   <= rx;
          rnd <= rnd + 4'd1;
          if (last) begin
            // key mix, domain separation, then absorb ciphertext block 0
            x          <= {cyp0, rx1, rx2, rx3 ^ k0, rx4 ^ k1 ^ 64'd1};
            pln0       <= rx0 ^ cyp0;
            rnd        <= START_B;
          end
        end
        DAT0: begin
          x   <= rx;
          rnd <= rnd + 4'd1;
          if (last) begin
            x    <= {cyp1, rx1, rx2, rx3, rx4};
            pln1 <= rx0 ^ cyp1;
            rnd  <= START_B;
          end
        end
        DAT1: begin
          x   <= rx;
          rnd <= rnd + 4'd1;
          if (last) begin
            // empty padded last block, then finalization key mix
            x   <= {rx0 ^ ASCON_PAD, rx1 ^ k0, rx2 ^ k1, rx3, rx4};
            rnd <= START_A;
          end
        end
        FINAL: begin
          x   <= rx;
          rnd <= rnd + 4'd1;
          if (last) begin
            x    <= {rx0, rx1, rx2, rx3 ^ k0, rx4 ^ k1};
            rnd  <= '0;
            busy <= 1'b0;
            done <= 1'b1;
`ifdef ASCON_DEC_TAG_CHECK_EN
            tag_ok <= ((rx3 ^ k0) == tag0) && ((rx4 ^ k1) == tag1);
            if (((rx3 ^ k0) != tag0) || ((rx4 ^ k1) != tag1)) begin
              pln0 <= '0;
              pln1 <= '0;
            end
`endif
          end
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_decrypt.sv
// Bench for ascon_decrypt: directed steps with a reference model built on
// the ASCON S-box lookup table, expected results queued at start and
// checked when done pulses. Also checks the round unit in isolation.
module tb_ascon_decrypt;

  logic        clk;
  logic        rst;
  logic        start;
  logic [63:0] iv, k0, k1, n0, n1, cyp0, cyp1;
  logic [63:0] y0, y1, y2, y3, y4, pln0, pln1;
  logic        busy, done;
  logic [2:0]  dbg_state;
`ifdef ASCON_DEC_TAG_CHECK_EN
  logic [63:0] tag0, tag1;
  logic        tag_ok;
`endif

  logic [319:0] rt_x, rt_next;
  logic [7:0]   rt_rc;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  ascon_decrypt dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .iv        (iv),
    .k0        (k0),
    .k1        (k1),
    .n0        (n0),
    .n1        (n1),
    .cyp0      (cyp0),
    .cyp1      (cyp1),
`ifdef ASCON_DEC_TAG_CHECK_EN
    .tag0      (tag0),
    .tag1      (tag1),
    .tag_ok    (tag_ok),
`endif
    .y0        (y0),
    .y1        (y1),
    .y2        (y2),
    .y3        (y3),
    .y4        (y4),
    .pln0      (pln0),
    .pln1      (pln1),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  ascon_round u_round_chk (
    .x      (rt_x),
    .rc     (rt_rc),
    .x_next (rt_next)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [4:0] sbox5(input logic [4:0] v);
    logic [4:0] o;
    case (v)
      5'h00: o = 5'h04; 5'h01: o = 5'h0b; 5'h02: o = 5'h1f; 5'h03: o = 5'h14;
      5'h04: o = 5'h1a; 5'h05: o = 5'h15; 5'h06: o = 5'h09; 5'h07: o = 5'h02;
      5'h08: o = 5'h1b; 5'h09: o = 5'h05; 5'h0a: o = 5'h08; 5'h0b: o = 5'h12;
      5'h0c: o = 5'h1d; 5'h0d: o = 5'h03; 5'h0e: o = 5'h06; 5'h0f: o = 5'h1c;
      5'h10: o = 5'h1e; 5'h11: o = 5'h13; 5'h12: o = 5'h07; 5'h13: o = 5'h0e;
      5'h14: o = 5'h00; 5'h15: o = 5'h0d; 5'h16: o = 5'h11; 5'h17: o = 5'h18;
      5'h18: o = 5'h10; 5'h19: o = 5'h0c; 5'h1a: o = 5'h01; 5'h1b: o = 5'h19;
      5'h1c: o = 5'h16; 5'h1d: o = 5'h0a; 5'h1e: o = 5'h0f; default: o = 5'h17;
    endcase
    return o;
  endfunction

  function automatic logic [63:0] m_ror(input logic [63:0] v, input int n);
    logic [127:0] d;
    d = {v, v};
    return d[n +: 64];
  endfunction

  function automatic logic [319:0] m_round(input logic [319:0] s, input logic [7:0] c);
    logic [63:0] a[5];
    logic [4:0]  col, o;
    for (int k = 0; k < 5; k++) a[k] = s[319 - 64*k -: 64];
    a[2] = a[2] ^ {56'd0, c};
    for (int j = 0; j < 64; j++) begin
      col = {a[0][j], a[1][j], a[2][j], a[3][j], a[4][j]};
      o = sbox5(col);
      a[0][j] = o[4]; a[1][j] = o[3]; a[2][j] = o[2]; a[3][j] = o[1]; a[4][j] = o[0];
    end
    a[0] = a[0] ^ m_ror(a[0], 19) ^ m_ror(a[0], 28);
    a[1] = a[1] ^ m_ror(a[1], 61) ^ m_ror(a[1], 39);
    a[2] = a[2] ^ m_ror(a[2], 1)  ^ m_ror(a[2], 6);
    a[3] = a[3] ^ m_ror(a[3], 10) ^ m_ror(a[3], 17);
    a[4] = a[4] ^ m_ror(a[4], 7)  ^ m_ror(a[4], 41);
    return {a[0], a[1], a[2], a[3], a[4]};
  endfunction

  function automatic logic [319:0] m_perm(input logic [319:0] s, input int first);
    logic [319:0] r;
    logic [3:0]   i4;
    r = s;
    for (int i = first; i < 12; i++) begin
      i4 = 4'(i);
      r = m_round(r, {4'hF - i4, i4});
    end
    return r;
  endfunction

  task automatic model_dec(input logic [63:0] c0, c1,
                           output logic [63:0] p0, p1, t3, t4);
    logic [319:0] s;
    s = m_perm({iv, k0, k1, n0, n1}, 0);
    s[127:0] = s[127:0] ^ {k0, k1} ^ 128'd1;
    p0 = s[319:256] ^ c0;
    s[319:256] = c0;
    s = m_perm(s, 6);
    p1 = s[319:256] ^ c1;
    s[319:256] = c1;
    s = m_perm(s, 6);
    s[319:256] = s[319:256] ^ 64'h8000000000000000;
    s[255:128] = s[255:128] ^ {k0, k1};
    s = m_perm(s, 0);
    t3 = s[127:64] ^ k0;
    t4 = s[63:0] ^ k1;
  endtask

  // ---------------- helpers ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [63:0] p0, p1, t3, t4);
    exp_q.push_back(p0);
    exp_q.push_back(p1);
    exp_q.push_back(t3);
    exp_q.push_back(t4);
  endtask

  // Start one operation, optionally re-pulse start at edge count restart_at,
  // then check latency and compare against the queued expectations.
  task automatic run_op(input int restart_at);
    int edges;
    start = 1'b1;
    tick;
    start = 1'b0;
    edges = 1;
    chk("load_y0", y0, iv);
    chk("load_y1", y1, k0);
    chk("load_y2", y2, k1);
    chk("load_y3", y3, n0);
    chk("load_y4", y4, n1);
    chk("load_busy", 64'(busy), 64'd1);
    while (done !== 1'b1 && edges < 60) begin
      if (edges == restart_at) start = 1'b1;
      tick;
      start = 1'b0;
      edges++;
    end
    chk("latency", 64'(edges), 64'd37);
    chk("done_hi", 64'(done), 64'd1);
    chk("busy_lo", 64'(busy), 64'd0);
    if (exp_q.size() >= 4) begin
      chk("pln0", pln0, exp_q.pop_front());
      chk("pln1", pln1, exp_q.pop_front());
      chk("tag_y3", y3, exp_q.pop_front());
      chk("tag_y4", y4, exp_q.pop_front());
    end else begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=%0d expected=4", exp_q.size());
    end
    tick;
    chk("done_pulse", 64'(done), 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [63:0] a_p0, a_p1, a_t3, a_t4;
    logic [63:0] b_p0, b_p1, b_t3, b_t4;
    logic [319:0] r_exp;

    rst = 1'b1; start = 1'b0;
    iv = 64'h80400C0600000000;
    k0 = 64'h265F1C12888E151A; k1 = 64'hC74F26B30A8C44B2;
    n0 = 64'h369C801F3AE8D0EA; n1 = 64'h9BF367D58FD211FF;
    cyp0 = '0; cyp1 = '0;
`ifdef ASCON_DEC_TAG_CHECK_EN
    tag0 = '0; tag1 = '0;
`endif
    rt_x = '0; rt_rc = '0;
    tick; tick;

    // reset state
    chk("rst_y0", y0, 64'd0);
    chk("rst_y3", y3, 64'd0);
    chk("rst_y4", y4, 64'd0);
    chk("rst_pln0", pln0, 64'd0);
    chk("rst_pln1", pln1, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);
    rst = 1'b0;
    tick;

    // run A: zero ciphertext
    model_dec(cyp0, cyp1, a_p0, a_p1, a_t3, a_t4);
`ifdef ASCON_DEC_TAG_CHECK_EN
    tag0 = a_t3; tag1 = a_t4;
`endif
    push_exp(a_p0, a_p1, a_t3, a_t4);
    run_op(-1);

    // run B: all-ones block 0 must invert plaintext block 0
    cyp0 = 64'hFFFFFFFFFFFFFFFF;
    model_dec(cyp0, cyp1, b_p0, b_p1, b_t3, b_t4);
`ifdef ASCON_DEC_TAG_CHECK_EN
    tag0 = b_t3; tag1 = b_t4;
`endif
    push_exp(~a_p0, b_p1, b_t3, b_t4);
    run_op(-1);

    // random ciphertext
    cyp0 = {$urandom, $urandom};
    cyp1 = {$urandom, $urandom};
    model_dec(cyp0, cyp1, b_p0, b_p1, b_t3, b_t4);
`ifdef ASCON_DEC_TAG_CHECK_EN
    tag0 = b_t3; tag1 = b_t4;
`endif
    push_exp(b_p0, b_p1, b_t3, b_t4);
    run_op(-1);

    // abort with reset sampled on edge E20
    cyp0 = '0; cyp1 = '0;
`ifdef ASCON_DEC_TAG_CHECK_EN
    tag0 = a_t3; tag1 = a_t4;
`endif
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int e = 1; e < 20; e++) tick;
    rst = 1'b1;
    tick;
    chk("abort_y0", y0, 64'd0);
    chk("abort_y2", y2, 64'd0);
    chk("abort_pln0", pln0, 64'd0);
    chk("abort_pln1", pln1, 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_state", 64'(dbg_state), 64'd0);
    rst = 1'b0;
    tick;
    push_exp(a_p0, a_p1, a_t3, a_t4);
    run_op(-1);

    // start re-pulsed while busy must be ignored
    push_exp(a_p0, a_p1, a_t3, a_t4);
    run_op(5);
    push_exp(a_p0, a_p1, a_t3, a_t4);
    run_op(20);

    // round unit in isolation
    rt_x = '0; rt_rc = 8'hF0;
    #1;
    r_exp = m_round(320'd0, 8'hF0);
    chk("round_x0", rt_next[319:256], r_exp[319:256]);
    chk("round_x2", rt_next[191:128], r_exp[191:128]);
    chk("round_x4", rt_next[63:0], r_exp[63:0]);
    rt_x = {$urandom, $urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom, $urandom};
    rt_rc = 8'h96;
    #1;
    r_exp = m_round(rt_x, 8'h96);
    chk("round_rand_x1", rt_next[255:192], r_exp[255:192]);
    chk("round_rand_x3", rt_next[127:64], r_exp[127:64]);

`ifdef ASCON_DEC_TAG_CHECK_EN
    // correct tag
    tag0 = a_t3; tag1 = a_t4;
    push_exp(a_p0, a_p1, a_t3, a_t4);
    run_op(-1);
    chk("tag_ok_good", 64'(tag_ok), 64'd1);
    // tag with bit 0 flipped clears plaintext
    tag0 = a_t3 ^ 64'd1;
    push_exp(64'd0, 64'd0, a_t3, a_t4);
    run_op(-1);
    chk("tag_ok_bad", 64'(tag_ok), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // hard time limit
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ascon_decrypt.md
Name: ascon_decrypt

Overview:
- Iterative ASCON-128 authenticated-decryption core: one permutation round per clock.
- Takes a 64-bit IV, a 128-bit key (k0,k1), a 128-bit nonce (n0,n1) and two full 64-bit ciphertext blocks (cyp0,cyp1); there is no associated data.
- Produces two plaintext blocks and exposes the live 320-bit state as y0..y4. After completion, y3/y4 hold the tag.
- Sits as the decrypt datapath under the crypto controller, which supplies stable inputs and a start pulse.

Parameters:
- ROUNDS_A, 12, rounds of the initialization and finalization permutation.
- ROUNDS_B, 6, rounds of the data-processing permutation.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request; sampled only in IDLE
- iv  input  64  initialization vector (ASCON-128 value 80400C0600000000)
- k0, k1  input  64 each  key, high word / low word
- n0, n1  input  64 each  nonce, high word / low word
- cyp0, cyp1  input  64 each  ciphertext blocks 0 and 1
- y0..y4  output  64 each  state registers x0..x4
- pln0, pln1  output  64 each  plaintext registers
- busy  output  1  high from the load edge until the last round edge
- done  output  1  one-cycle pulse on completion

Behaviour:
- Reset: state, pln0, pln1, busy, done = 0; FSM goes to IDLE. Reset mid-operation aborts immediately and discards the operation.
- FSM states: IDLE, INIT, DAT0, DAT1, FINAL. A round counter runs within each state.
- IDLE, start=1 (edge E0): load state = {iv,k0,k1,n0,n1}, set busy=1, go to INIT. start is ignored in every other state.
- Round function, applied on each busy edge:
  - Constant addition: x2 ^= {(15-i)<<4 | i}, where i is the round index 0..11.
  - p12 uses i = 0..11. p6 uses i = 6..11.
  - 5-bit bitsliced S-box layer, per the ASCON specification.
  - Linear layer (rotate-right amounts): x0 19/28, x1 61/39, x2 1/6, x3 10/17, x4 7/41.
- INIT, 12 rounds (E1..E12). On E12, after the round:
  - x3 ^= k0, x4 ^= k1, then x4 ^= 1 (domain separation, no AD).
  - pln0 <= x0 ^ cyp0, then x0 <= cyp0.
  - Go to DAT0.
- DAT0, 6 rounds (E13..E18). On E18: pln1 <= x0 ^ cyp1, x0 <= cyp1; go to DAT1.
- DAT1, 6 rounds (E19..E24). On E24:
  - x0 ^= 8000000000000000 (empty padded final block).
  - x1 ^= k0, x2 ^= k1.
  - Go to FINAL.
- FINAL, 12 rounds (E25..E36). On E36: x3 ^= k0, x4 ^= k1; go to IDLE, busy=0, done=1 for exactly one cycle.
- Latency: done is high in the cycle after E36, i.e. 37 edges after the start edge.
- Plaintext validity: pln0 valid from E12, pln1 valid from E18; both hold until the next start or reset.
- Input stability: inputs must be stable from the start edge until E18. Key inputs must stay stable through E36.
- Post-round operations use the round output combinationally within the same edge.

Optional Feature:
- Macro ASCON_DEC_TAG_CHECK_EN.
- When defined, adds:
  - inputs tag0, tag1 (64 each);
  - output tag_ok (1 bit), registered on E36 as (x3^k0)==tag0 && (x4^k1)==tag1;
  - pln0/pln1 forced to 0 on E36 when tag_ok is 0.
  - tag_ok resets to 0.
- When undefined, these ports are absent and plaintext is never cleared.

Decomposition:
- Package ascon_pkg holds:
  - the IV constant 80400C0600000000;
  - the round-constant function;
  - the FSM state enum;
  - the pad constant;
  - a 64-bit rotate-right function.
- Sub-module ascon_round: purely combinational single round (320-bit state plus 8-bit constant in, 320-bit state out).
- ascon_decrypt holds the FSM, counters and register file.

Test Plan:
- Vector from start: iv=80400C0600000000, k0=265F1C12888E151A, k1=C74F26B30A8C44B2, n0=369C801F3AE8D0EA, n1=9BF367D58FD211FF, cyp0=cyp1=0, pulse start. Required:
  - one cycle after the load edge, y0..y4 = {iv,k0,k1,n0,n1} and busy=1;
  - done pulses exactly 37 edges after start;
  - pln0, pln1, y3, y4 match the ASCON-128 C reference model.
- Same vector with cyp0=FFFFFFFFFFFFFFFF: pln0 equals the bitwise inverse of the pln0 from the cyp0=0 run.
- Reset asserted at E20: all outputs 0 next cycle, FSM idle; a following start produces the full correct result.
- start re-pulsed during busy: ignored; result and timing are identical to an uninterrupted run.
- Round unit, isolated: state all zero, constant F0 -> compare against the reference single-round output.
- With ASCON_DEC_TAG_CHECK_EN:
  - correct tag gives tag_ok=1 and nonzero plaintext per the model;
  - a tag with bit 0 flipped gives tag_ok=0 and pln0=pln1=0.
